// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file widths and the writeback entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: producer requests, register-file write port and hazard query bundle
interface writeback_queue_if;
  logic alu_valid;
  logic [riscv_pkg::REG_ADDR_W-1:0] alu_rd;
  logic [riscv_pkg::XLEN-1:0] alu_data;
  logic alu_ready;
  logic ld_valid;
  logic [riscv_pkg::REG_ADDR_W-1:0] ld_rd;
  logic [riscv_pkg::XLEN-1:0] ld_data;
  logic ld_ready;
  logic [riscv_pkg::REG_ADDR_W-1:0] A3;
  logic [riscv_pkg::XLEN-1:0] WD3;
  logic WE;
  logic [riscv_pkg::REG_ADDR_W-1:0] q_rs1, q_rs2;
  logic rs1_busy, rs2_busy;
  logic [riscv_pkg::XLEN-1:0] rs1_fwd, rs2_fwd;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_rs1, q_rs2,
    input alu_ready, ld_ready, A3, WD3, WE, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q_rs1, q_rs2,
    output alu_ready, ld_ready, A3, WD3, WE, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd
  );
endinterface

// File: rtl/wbq_fifo.sv
// wbq_fifo: dual-push single-pop entry store; entries exposed oldest-first (optional WBQ_FORWARD_EN data view)
module wbq_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic [1:0] n_push,
  input  wb_entry_t e0,
  input  wb_entry_t e1,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t head,
  output logic ent_valid [DEPTH],
  output logic [REG_ADDR_W-1:0] ent_rd [DEPTH]
`ifdef WBQ_FORWARD_EN
  ,
  output logic [XLEN-1:0] ent_data [DEPTH]
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic pop;
  assign pop = count != '0;
  assign head = mem[rptr];
  always_ff @(posedge clk) begin
    if (Reset) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (n_push != 2'd0) mem[wptr] <= e0;
      if (n_push == 2'd2) mem[wptr + AW'(1)] <= e1;
      wptr <= wptr + AW'(n_push);
      rptr <= rptr + AW'(pop);
      count <= count + CW'(n_push) - CW'(pop);
    end
  end
  // index k is age order: 0 is the head, higher k is younger
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    assign ent_valid[k] = CW'(k) < count;
    assign ent_rd[k] = mem[rptr + AW'(k)].rd;
`ifdef WBQ_FORWARD_EN
    assign ent_data[k] = mem[rptr + AW'(k)].data;
`endif
  end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: arbitrates ALU/load writebacks into a FIFO feeding an active-low register-file write port
// Define WBQ_FORWARD_EN to build rs1_fwd/rs2_fwd forwarding from the youngest matching entry.
module writeback_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic Reset,
  writeback_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  wb_entry_t head, e0, e1;
  logic ent_valid [DEPTH];
  logic [REG_ADDR_W-1:0] ent_rd [DEPTH];
  logic ld_take, ld_push, alu_push, b1, b2;
  logic [1:0] n_push;
  assign ld_take = bus.ld_valid && bus.ld_rd != '0;
  // x0 requests are always acknowledged and silently dropped
  assign bus.ld_ready = !Reset && (bus.ld_rd == '0 || count < CW'(DEPTH));
  assign bus.alu_ready = !Reset && (bus.alu_rd == '0 || count + CW'(ld_take) < CW'(DEPTH));
  assign ld_push = ld_take && bus.ld_ready;
  assign alu_push = bus.alu_valid && bus.alu_rd != '0 && bus.alu_ready;
  assign n_push = {1'b0, ld_push} + {1'b0, alu_push};
  assign e0 = ld_push ? wb_entry_t'{rd: bus.ld_rd, data: bus.ld_data}
                      : wb_entry_t'{rd: bus.alu_rd, data: bus.alu_data};
  assign e1 = wb_entry_t'{rd: bus.alu_rd, data: bus.alu_data};
`ifdef WBQ_FORWARD_EN
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [XLEN-1:0] f1, f2;
`endif
  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .Reset(Reset),
    .n_push(n_push),
    .e0(e0),
    .e1(e1),
    .count(count),
    .head(head),
    .ent_valid(ent_valid),
    .ent_rd(ent_rd)
`ifdef WBQ_FORWARD_EN
    ,
    .ent_data(ent_data)
`endif
  );
  assign bus.WE = count == '0;
  assign bus.A3 = bus.WE ? '0 : head.rd;
  assign bus.WD3 = bus.WE ? '0 : head.data;
  always_comb begin
    b1 = 1'b0;
    b2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      b1 = b1 | (ent_valid[k] && ent_rd[k] == bus.q_rs1);
      b2 = b2 | (ent_valid[k] && ent_rd[k] == bus.q_rs2);
    end
  end
  assign bus.rs1_busy = b1 && bus.q_rs1 != '0;
  assign bus.rs2_busy = b2 && bus.q_rs2 != '0;
`ifdef WBQ_FORWARD_EN
  // scanning oldest to youngest lets the youngest match win
  always_comb begin
    f1 = '0;
    f2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && ent_rd[k] == bus.q_rs1) f1 = ent_data[k];
      if (ent_valid[k] && ent_rd[k] == bus.q_rs2) f2 = ent_data[k];
    end
  end
  assign bus.rs1_fwd = bus.rs1_busy ? f1 : '0;
  assign bus.rs2_fwd = bus.rs2_busy ? f2 : '0;
`else
  assign bus.rs1_fwd = '0;
  assign bus.rs2_fwd = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: scoreboard bench for writeback_queue (DEPTH=4 main instance, DEPTH=2 for the full case)
module tb_writeback_queue;
  import riscv_pkg::*;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;
  writeback_queue_if bus ();
  writeback_queue_if bus2 ();
  writeback_queue #(.DEPTH(4)) dut (.clk(clk), .Reset(Reset), .bus(bus));
  writeback_queue #(.DEPTH(2)) dut2 (.clk(clk), .Reset(Reset), .bus(bus2));
  int errors = 0;
  int checks = 0;
  wb_entry_t sb [$];
  wb_entry_t mon_e;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus2.alu_valid = 1'b0; bus2.alu_rd = '0; bus2.alu_data = '0;
    bus2.ld_valid = 1'b0; bus2.ld_rd = '0; bus2.ld_data = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid = 1'b1; bus.ld_rd = rd; bus.ld_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back(wb_entry_t'{rd: rd, data: d});
  endtask

  // every write-port cycle must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (bus.WE === 1'b0) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_write: got A3=%0d WD3=%h expected no write", bus.A3, bus.WD3);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_rd", 32'(bus.A3), 32'(mon_e.rd));
        chk("wr_data", bus.WD3, mon_e.data);
      end
    end
  end

  initial begin
    idle();
    bus.q_rs1 = 5'd7; bus.q_rs2 = 5'd0;
    bus2.q_rs1 = 5'd0; bus2.q_rs2 = 5'd0;
    repeat (2) tick();
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(bus.WE), 32'd1);
    chk("rst_a3", 32'(bus.A3), 32'd0);
    chk("rst_wd3", bus.WD3, 32'd0);
    chk("rst_busy", 32'(bus.rs1_busy), 32'd0);
    chk("rst_fwd", bus.rs1_fwd, 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);

    tick();
    alu(5'd5, 32'hDEADBEEF); expect_wr(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick(); idle();
    tick();
    @(negedge clk);
    chk("single_we_idle", 32'(bus.WE), 32'd1);

    tick();
    ld(5'd3, 32'h11); alu(5'd4, 32'h22);
    expect_wr(5'd3, 32'h11); expect_wr(5'd4, 32'h22);
    @(negedge clk);
    chk("dual_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("dual_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick(); idle();
    repeat (2) tick();
    @(negedge clk);
    chk("dual_we_idle", 32'(bus.WE), 32'd1);

    tick();
    ld(5'd10, 32'h100); alu(5'd11, 32'h101);
    expect_wr(5'd10, 32'h100); expect_wr(5'd11, 32'h101);
    tick();
    ld(5'd12, 32'h102); alu(5'd13, 32'h103);
    expect_wr(5'd12, 32'h102); expect_wr(5'd13, 32'h103);
    @(negedge clk);
    chk("occ2_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    ld(5'd14, 32'h104); alu(5'd15, 32'h105);
    expect_wr(5'd14, 32'h104);
    @(negedge clk);
    chk("occ3_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("occ3_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    expect_wr(5'd15, 32'h105);
    @(negedge clk);
    chk("occ3_alu_ready_alone", 32'(bus.alu_ready), 32'd1);
    tick(); idle();
    repeat (4) tick();
    @(negedge clk);
    chk("occ_we_idle", 32'(bus.WE), 32'd1);

    tick();
    bus2.ld_valid = 1'b1; bus2.ld_rd = 5'd1; bus2.ld_data = 32'h1;
    bus2.alu_valid = 1'b1; bus2.alu_rd = 5'd2; bus2.alu_data = 32'h2;
    tick();
    @(negedge clk);
    chk("full_ld_ready", 32'(bus2.ld_ready), 32'd0);
    chk("full_alu_ready", 32'(bus2.alu_ready), 32'd0);
    chk("full_we", 32'(bus2.WE), 32'd0);
    chk("full_a3_first", 32'(bus2.A3), 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("full_a3_second", 32'(bus2.A3), 32'd2);
    chk("full_wd3_second", bus2.WD3, 32'h2);
    tick();
    @(negedge clk);
    chk("full_we_idle", 32'(bus2.WE), 32'd1);

    tick();
    alu(5'd0, 32'h55); ld(5'd0, 32'h66);
    @(negedge clk);
    chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("x0_ld_ready", 32'(bus.ld_ready), 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("x0_we", 32'(bus.WE), 32'd1);
    tick();
    @(negedge clk);
    chk("x0_we_later", 32'(bus.WE), 32'd1);

    tick();
    bus.q_rs1 = 5'd7; bus.q_rs2 = 5'd8;
    ld(5'd7, 32'hA); alu(5'd7, 32'hB);
    expect_wr(5'd7, 32'hA); expect_wr(5'd7, 32'hB);
    @(negedge clk);
    chk("haz_busy_empty", 32'(bus.rs1_busy), 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("haz_rs1_busy_two", 32'(bus.rs1_busy), 32'd1);
    chk("haz_rs2_busy_other", 32'(bus.rs2_busy), 32'd0);
    chk("haz_rs1_fwd_youngest", bus.rs1_fwd, FWD ? 32'hB : 32'h0);
    chk("haz_rs2_fwd_zero", bus.rs2_fwd, 32'h0);
    tick();
    @(negedge clk);
    chk("haz_rs1_busy_one", 32'(bus.rs1_busy), 32'd1);
    chk("haz_rs1_fwd_one", bus.rs1_fwd, FWD ? 32'hB : 32'h0);
    tick();
    @(negedge clk);
    chk("haz_rs1_busy_clear", 32'(bus.rs1_busy), 32'd0);
    chk("haz_rs1_fwd_clear", bus.rs1_fwd, 32'h0);

    tick();
    bus.q_rs1 = 5'd22;
    ld(5'd20, 32'h200); alu(5'd21, 32'h201);
    expect_wr(5'd20, 32'h200); expect_wr(5'd21, 32'h201);
    tick();
    ld(5'd22, 32'h202); alu(5'd23, 32'h203);
    expect_wr(5'd22, 32'h202); expect_wr(5'd23, 32'h203);
    tick(); idle();
    Reset = 1'b1;
    @(negedge clk);
    chk("mid_busy_before", 32'(bus.rs1_busy), 32'd1);
    tick();
    Reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_we", 32'(bus.WE), 32'd1);
    chk("mid_busy", 32'(bus.rs1_busy), 32'd0);
    chk("mid_fwd", bus.rs1_fwd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("mid_we_after", 32'(bus.WE), 32'd1);
    end

    repeat (2) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
